wide_add_seq: RTL and testbench

//  Byte-serial controller that drives one shared 8-bit ripple adder (FA_8bit) to add NBYTES-wide

---
 rtl/iir_pkg.sv | 12 +
 rtl/wide_add_seq_fa_8bit.sv | 26 ++
 rtl/wide_add_seq.sv | 127 ++++++++++++
 tb/tb_wide_add_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR datapath: FSM state encoding and byte width.
package iir_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_fa_8bit.sv
// FA_8bit: plain 8-bit ripple-carry adder, the single arithmetic resource
// that wide_add_seq reuses once per byte.
module FA_8bit
    import iir_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout
);

    logic r_c;

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        r_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ r_c;
            r_c      = (i_a[i] & i_b[i]) | (r_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = r_c;
    end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: byte-serial wide adder. One FA_8bit is stepped across the
// NBYTES bytes of the operands, carry held in a register between cycles.
// Optional subtract mode is enabled by defining WIDE_ADD_SEQ_SUB_EN, which
// adds the 'sub' port; otherwise the block always computes A+B+c_in.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side accepts only in IDLE; output side holds result,
// c_out and ovf stable from out_valid rising until out_ready is sampled high.
module wide_add_seq
    import iir_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NBYTES-1:0]      a,
    input  logic [8*NBYTES-1:0]      b,
    input  logic                     c_in,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic                     sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NBYTES-1:0]      result,
    output logic                     c_out,
    output logic                     ovf,
    output logic [1:0]               dbg_state
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int CNT_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_carry;
    logic [CNT_W-1:0]     r_cnt;
    logic [W-1:0]         r_result;
    logic                 r_c_out;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [CNT_W+2:0]     w_base;
    logic [BYTE_W-1:0]    w_sum;
    logic                 w_cout;
    logic [W-1:0]         w_b_lat;
    logic                 w_c_lat;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == LAST_BYTE);
    assign w_base   = {r_cnt, 3'b000};

    // Operand B and initial carry as latched on accept; subtract is A + ~B + 1.
`ifdef WIDE_ADD_SEQ_SUB_EN
    assign w_b_lat = sub ? ~b : b;
    assign w_c_lat = sub ? 1'b1 : c_in;
`else
    assign w_b_lat = b;
    assign w_c_lat = c_in;
`endif

    FA_8bit u_fa (
        .i_a    (r_a[w_base +: BYTE_W]),
        .i_b    (r_b[w_base +: BYTE_W]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: accept in IDLE, step bytes in RUN, wait for consumer in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, write one sum byte per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_lat;
            r_carry <= w_c_lat;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_result[w_base +: BYTE_W] <= w_sum;
            r_carry                    <= w_cout;
            if (w_last) begin
                r_cnt   <= '0;
                r_c_out <= w_cout;
                r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum[BYTE_W-1] != r_a[W-1]);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (NBYTES=4) with an arithmetic reference
// model, an expected-result queue and a per-cycle output compare.
module tb_wide_add_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    logic prev_valid = 1'b0;

    // expected {ovf, c_out, result}
    logic [W+1:0] exp_q[$];

    wide_add_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference model: plain wide arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   s;
        logic         o;
        bb = ms ? ~mb : mb;
        cc = ms ? 1'b1 : mc;
        s  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, cc};
        o  = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
        return {o, s[W], s[W-1:0]};
    endfunction

    // compare process: every cycle out_valid is high, outputs must match queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'(1'b0));
                end else begin
                    check("cmp_result", 64'(result), 64'(exp_q[0][W-1:0]));
                    check("cmp_c_out",  64'(c_out),  64'(exp_q[0][W]));
                    check("cmp_ovf",    64'(ovf),    64'(exp_q[0][W+1]));
                    check("cmp_in_ready_in_done", 64'(in_ready), 64'(1'b0));
                    if (!prev_valid)
                        check("cmp_latency", 64'(cyc - accept_cyc), 64'(NBYTES));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // driver: present one operation in IDLE, accepted on the next edge
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1'b1));
        a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
        exp_q.push_back(model(ta, tb, tc, ts));
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // wait for result, pin literal expectation, then complete handshake
    task automatic wait_done(input string name, input logic [W-1:0] er, input logic ec,
                             input logic eo, input int hold);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, 64'(out_valid), 64'(1'b1));
            exp_q.delete();
            return;
        end
        check({name, "_result"}, 64'(result), 64'(er));
        check({name, "_c_out"},  64'(c_out),  64'(ec));
        check({name, "_ovf"},    64'(ovf),    64'(eo));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            // new request while busy must be ignored
            a = 32'hDEADBEEF; b = 32'h01010101; in_valid = 1'b1;
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(out_valid), 64'(1'b1));
            check({name, "_hold_in_ready"}, 64'(in_ready), 64'(1'b0));
            check({name, "_hold_result"}, 64'(result), 64'(er));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, 64'(out_valid), 64'(1'b0));
        check({name, "_post_in_ready"}, 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready",  64'(in_ready),  64'(1'b1));
        check("reset_out_valid", 64'(out_valid), 64'(1'b0));
        check("reset_result",    64'(result),    64'(0));
        check("reset_c_out",     64'(c_out),     64'(1'b0));
        check("reset_ovf",       64'(ovf),       64'(1'b0));

        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        wait_done("byte_carry", 32'h00000100, 1'b0, 1'b0, 0);

        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_done("wrap", 32'h00000000, 1'b1, 1'b0, 0);

        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_done("pos_ovf", 32'h80000000, 1'b0, 1'b1, 0);

        do_op(32'h12345678, 32'h11111111, 1'b1, 1'b0);
        wait_done("cin", 32'h2345678A, 1'b0, 1'b0, 0);

        do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0);
        wait_done("hold_neg_ovf", 32'h00000000, 1'b1, 1'b1, 5);
        repeat (6) @(posedge clk);
        #1 check("no_ghost_op", 64'(out_valid), 64'(1'b0));

        // abort during byte 2
        do_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check("abort_out_valid", 64'(out_valid), 64'(1'b0));
        check("abort_in_ready",  64'(in_ready),  64'(1'b1));
        check("abort_result",    64'(result),    64'(0));
        check("abort_c_out",     64'(c_out),     64'(1'b0));

        do_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0);
        wait_done("after_abort", 32'h00000000, 1'b1, 1'b0, 0);

`ifdef WIDE_ADD_SEQ_SUB_EN
        do_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
        wait_done("sub_borrow", 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        do_op(32'h00000007, 32'h00000005, 1'b0, 1'b1);
        wait_done("sub_noborrow", 32'h00000002, 1'b1, 1'b0, 0);
`endif

        repeat (3) @(posedge clk);
        #1 check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
